serial_uart_port: RTL and testbench
===================================

# serial_uart_port

Serial line engine for the memory-mapped serial buffer: the device-side end of its byte handshake. Serializes bytes written by the buffer onto `tx_out` as 8N1 UART frames. Deserializes frames from `rx_in` into a one-byte holding register that the buffer polls and pops. Sits between the buffer and the FPGA UART pins, in the `clock` domain.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range 4..65535.
- `clock`  input  1  system clock, all logic on rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `wren_in`  input  1  one-cycle pulse: transmit `data_in`.
- `data_in`  input  8  byte to transmit, sampled with `wren_in`.
- `ready_out`  output  1  transmitter idle, can accept `wren_in`.
- `rden_in`  input  1  one-cycle pulse: pop the received byte.
- `data_out`  output  8  received byte; valid while `data_valid_out`=1.
- `data_valid_out`  output  1  holding register contains an unread byte.
- `overrun_out`  output  1  sticky: a good frame was dropped because the holding register was full.
- `rx_in`  input  1  asynchronous serial input, idle high.
- `tx_out`  output  1  serial output, idle high.

## Operation
- Reset values: `tx_out`=1, `ready_out`=1, `data_out`=0x00, `data_valid_out`=0, `overrun_out`=0. RX synchronizer flops reset to 1. Both FSMs reset to IDLE. A reset mid-frame abandons the frame with no partial output.
- TX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE with `wren_in`=1: latch `data_in` and go to START.
  - `wren_in` outside IDLE is ignored. Nothing is queued.
  - Bits go out LSB first. Each state holds `tx_out` for CLKS_PER_BIT cycles. DATA advances a 3-bit index from 0 to 7.
  - STOP drives 1, then the FSM returns to IDLE.
- RX path: two-flop synchronizer on `rx_in`. RX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: a synchronized 1->0 transition enters START.
  - START: wait CLKS_PER_BIT/2 (floor) cycles and re-sample. If the line is 1, treat it as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample once. A value of 0 is a framing error; discard the byte and return to IDLE. The FSM also waits for the line to be high before it re-arms.
  - Good frame: if `data_valid_out`=0, load `data_out` and set `data_valid_out`. If `data_valid_out`=1 and `rden_in`=0 in the same cycle, drop the byte, set `overrun_out`, and leave `data_out` unchanged.
- Pop: `rden_in` while `data_valid_out`=1 clears `data_valid_out` next cycle. `data_out` keeps its last value. `rden_in` while empty has no effect.
- Simultaneous pop and frame completion: load the new byte, keep `data_valid_out`=1, no overrun.
- `overrun_out` clears only on reset.

## Timing
- TX: `wren_in` sampled high in IDLE at edge N gives `ready_out`=0 and `tx_out`=0 from N+1.
  - Frame length is 10×CLKS_PER_BIT cycles (11× with parity).
  - `ready_out` returns to 1 in the cycle after the last STOP cycle.
  - A back-to-back `wren_in` on that cycle starts the next start bit immediately, with no extra idle cycles.
- RX: 2 cycles of synchronizer latency.
  - `data_valid_out` rises at most 2 + (9.5 × CLKS_PER_BIT) + 2 cycles after the falling edge of the start bit on `rx_in` (+CLKS_PER_BIT with parity).
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `SERIAL_UART_PARITY_EN` defined:
  - TX inserts an even-parity bit (XOR of the 8 data bits) between DATA and STOP.
  - RX samples that bit in PARITY. On a mismatch the frame is discarded like a framing error: `data_valid_out` is not set and `overrun_out` is not touched.
  - Frame length becomes 11 bits.
- Macro undefined: PARITY states are absent, frames are 8N1, 10 bits.

## Test plan
- Reset: `reset_n`=0 for 3 cycles with `rx_in`=1 -> `tx_out`=1, `ready_out`=1, `data_valid_out`=0, `overrun_out`=0, `data_out`=0x00.
- TX, CLKS_PER_BIT=4: pulse `wren_in` with 0xA5 -> `tx_out` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `ready_out`=0 for 40 cycles. A second `wren_in` (0x3C) mid-frame is ignored.
- RX: drive frame 0x5A with CLKS_PER_BIT=4 -> `data_valid_out`=1, `data_out`=0x5A. Pulse `rden_in` -> `data_valid_out`=0 next cycle.
- Overrun: receive 0x11 then 0x22 without popping -> `data_out`=0x11, `overrun_out`=1. Repeat with `rden_in` on the exact completion cycle of 0x22 -> `data_out`=0x22, `data_valid_out`=1, `overrun_out` stays 0 after reset.
- Errors: a 1-cycle low glitch on `rx_in` -> no byte. A frame with stop bit 0 -> no byte, `data_valid_out` stays 0. With the macro, a frame for 0x03 with parity bit 1 -> discarded.
- Reset mid-frame: assert `reset_n`=0 during TX bit 4 -> `tx_out`=1 and `ready_out`=1 after the reset cycle. A new `wren_in` with 0x81 then produces a full, correct frame.

Source files
------------

// File: rtl/serial_uart_port.sv
// UART serial line engine: 8N1 transmitter and receiver with a one-byte RX holding register.
// Define SERIAL_UART_PARITY_EN to add an even-parity bit to both directions (8E1 framing).
module serial_uart_port #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wren_in,
  input  logic [7:0] data_in,
  output logic       ready_out,
  input  logic       rden_in,
  output logic [7:0] data_out,
  output logic       data_valid_out,
  output logic       overrun_out,
  input  logic       rx_in,
  output logic       tx_out
);

  localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef SERIAL_UART_PARITY_EN
    TX_PARITY = 3'd4,
`endif
    TX_STOP   = 3'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef SERIAL_UART_PARITY_EN
    RX_PARITY = 3'd4,
`endif
    RX_STOP   = 3'd3
  } rx_state_t;

`ifdef SERIAL_UART_PARITY_EN
  function automatic logic f_even_parity(input logic [7:0] i_d);
    return ^i_d;
  endfunction
`endif

  // ---------------- transmitter ----------------
  tx_state_t   r_tx_state;
  tx_state_t   w_tx_state_nxt;
  logic [15:0] r_tx_cnt;
  logic [15:0] w_tx_cnt_nxt;
  logic [2:0]  r_tx_idx;
  logic [2:0]  w_tx_idx_nxt;
  logic [7:0]  r_tx_data;
  logic [7:0]  w_tx_data_nxt;
  logic        w_tx_bit_nxt;
  logic        w_tx_done;
  logic        r_tx_out;
  logic        r_ready;

  assign w_tx_done = (r_tx_cnt == LP_BIT_LAST);

  // TX next-state, bit counter and the line level of the next cycle
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_data_nxt  = r_tx_data;
    w_tx_bit_nxt   = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (wren_in) begin
          w_tx_state_nxt = TX_START;
          w_tx_data_nxt  = data_in;
          w_tx_cnt_nxt   = 16'd0;
          w_tx_idx_nxt   = 3'd0;
        end else begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      TX_START: begin
        if (w_tx_done) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = 16'd0;
          w_tx_idx_nxt   = 3'd0;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (w_tx_done) begin
          w_tx_cnt_nxt = 16'd0;
          if (r_tx_idx == 3'd7) begin
`ifdef SERIAL_UART_PARITY_EN
            w_tx_state_nxt = TX_PARITY;
`else
            w_tx_state_nxt = TX_STOP;
`endif
          end else begin
            w_tx_idx_nxt = r_tx_idx + 3'd1;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
`ifdef SERIAL_UART_PARITY_EN
      TX_PARITY: begin
        if (w_tx_done) begin
          w_tx_state_nxt = TX_STOP;
          w_tx_cnt_nxt   = 16'd0;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
`endif
      TX_STOP: begin
        if (w_tx_done) begin
          w_tx_state_nxt = TX_IDLE;
          w_tx_cnt_nxt   = 16'd0;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_cnt_nxt   = 16'd0;
      end
    endcase
    // Line level follows the state being entered so tx_out can be a flop
    case (w_tx_state_nxt)
      TX_IDLE:   w_tx_bit_nxt = 1'b1;
      TX_START:  w_tx_bit_nxt = 1'b0;
      TX_DATA:   w_tx_bit_nxt = w_tx_data_nxt[w_tx_idx_nxt];
`ifdef SERIAL_UART_PARITY_EN
      TX_PARITY: w_tx_bit_nxt = f_even_parity(w_tx_data_nxt);
`endif
      TX_STOP:   w_tx_bit_nxt = 1'b1;
      default:   w_tx_bit_nxt = 1'b1;
    endcase
  end

  // TX state and registered line/ready outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_idx   <= 3'd0;
      r_tx_data  <= 8'h00;
      r_tx_out   <= 1'b1;
      r_ready    <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_out   <= w_tx_bit_nxt;
      r_ready    <= (w_tx_state_nxt == TX_IDLE);
    end
  end

  // ---------------- receiver ----------------
  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_prev;
  logic        w_rx_fall;
  rx_state_t   r_rx_state;
  rx_state_t   w_rx_state_nxt;
  logic [15:0] r_rx_cnt;
  logic [15:0] w_rx_cnt_nxt;
  logic [2:0]  r_rx_idx;
  logic [2:0]  w_rx_idx_nxt;
  logic [7:0]  r_rx_shift;
  logic [7:0]  w_rx_shift_nxt;
  logic        w_rx_done;
  logic        w_rx_good;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_overrun;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // A fresh 1->0 edge is required, so the line must return high before re-arming
  assign w_rx_fall = r_rx_prev & ~r_rx_sync;
  assign w_rx_done = (r_rx_cnt == LP_BIT_LAST);

  // RX next-state, mid-bit sampling and good-frame detection
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_good      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = 16'd0;
        end else begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_rx_cnt == LP_HALF_LAST) begin
          w_rx_cnt_nxt = 16'd0;
          w_rx_idx_nxt = 3'd0;
          if (r_rx_sync) begin
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_state_nxt = RX_DATA;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (w_rx_done) begin
          w_rx_cnt_nxt   = 16'd0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7) begin
`ifdef SERIAL_UART_PARITY_EN
            w_rx_state_nxt = RX_PARITY;
`else
            w_rx_state_nxt = RX_STOP;
`endif
          end else begin
            w_rx_idx_nxt = r_rx_idx + 3'd1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 16'd1;
        end
      end
`ifdef SERIAL_UART_PARITY_EN
      RX_PARITY: begin
        if (w_rx_done) begin
          w_rx_cnt_nxt = 16'd0;
          if (r_rx_sync == f_even_parity(r_rx_shift)) begin
            w_rx_state_nxt = RX_STOP;
          end else begin
            w_rx_state_nxt = RX_IDLE;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 16'd1;
        end
      end
`endif
      RX_STOP: begin
        if (w_rx_done) begin
          w_rx_state_nxt = RX_IDLE;
          w_rx_cnt_nxt   = 16'd0;
          w_rx_good      = r_rx_sync;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 16'd1;
        end
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
        w_rx_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // RX state registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_idx   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // Holding register: a pop in the completion cycle makes room for the new byte
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_rx_good) begin
      if (!r_valid || rden_in) begin
        r_data  <= r_rx_shift;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (rden_in && r_valid) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign tx_out         = r_tx_out;
  assign ready_out      = r_ready;
  assign data_out       = r_data;
  assign data_valid_out = r_valid;
  assign overrun_out    = r_overrun;

endmodule

// File: tb/tb_serial_uart_port.sv
// Self-checking bench for serial_uart_port: directed cases plus randomized RX/TX/pop
// operations checked against a frame-level reference model.
module tb_serial_uart_port;

  localparam int LP_CPB = 4;
`ifdef SERIAL_UART_PARITY_EN
  localparam int LP_NBITS = 11;
`else
  localparam int LP_NBITS = 10;
`endif
  localparam int LP_LAT_MAX = 2 + (19 * LP_CPB) / 2 + 2 + (LP_NBITS - 10) * LP_CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wren_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready_out;
  logic       rden_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       overrun_out;
  logic       rx_in = 1'b1;
  logic       tx_out;

  int n_cmp = 0;
  int n_err = 0;

  // reference model of the receive holding register
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_ovr   = 1'b0;

  serial_uart_port #(.CLKS_PER_BIT(LP_CPB)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wren_in        (wren_in),
    .data_in        (data_in),
    .ready_out      (ready_out),
    .rden_in        (rden_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .overrun_out    (overrun_out),
    .rx_in          (rx_in),
    .tx_out         (tx_out)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    exp_ovr   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_in   = 1'b1;
    wren_in = 1'b0;
    rden_in = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    model_clear();
    @(negedge clock);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stop_b,
                                             input logic par_flip);
    logic [10:0] fb;
`ifdef SERIAL_UART_PARITY_EN
    fb = {stop_b, (^b) ^ par_flip, b, 1'b0};
`else
    fb = {1'b0, stop_b, b, 1'b0};
`endif
    return fb;
  endfunction

  // Starts at a negedge; checks every line cycle of the frame, then ready.
  task automatic tx_frame(input logic [7:0] b, input int inject_k, input int abort_k);
    logic [10:0] fb;
    fb = frame_bits(b, 1'b1, 1'b0);
    wren_in = 1'b1;
    data_in = b;
    @(posedge clock);
    #1;
    wren_in = 1'b0;
    data_in = 8'($urandom);
    for (int k = 0; k < LP_NBITS * LP_CPB; k++) begin
      if (k == inject_k) begin
        wren_in = 1'b1;
        data_in = 8'h3C;
      end else begin
        wren_in = 1'b0;
      end
      if (k == abort_k) reset_n = 1'b0;
      @(negedge clock);
      if (k == abort_k) begin
        chk("tx_abort_line", tx_out, 1'b1);
        chk("tx_abort_ready", ready_out, 1'b1);
        reset_n = 1'b1;
        model_clear();
        return;
      end
      chk("tx_bit", tx_out, fb[k / LP_CPB]);
      chk("tx_busy", ready_out, 1'b0);
    end
    wren_in = 1'b0;
    @(negedge clock);
    chk("tx_ready_back", ready_out, 1'b1);
    chk("tx_idle_line", tx_out, 1'b1);
  endtask

  // Drives one frame on rx_in, optionally pops at edge pop_at (counted from the start edge),
  // updates the model and checks the holding register afterwards.
  task automatic rx_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                          input int pop_at, output int lat);
    logic [10:0] fb;
    logic        was_valid;
    logic        good;
    fb        = frame_bits(b, stop_b, par_flip);
    was_valid = exp_valid;
    good      = stop_b && !par_flip;
    lat       = -1;
    @(posedge clock);
    #1;
    for (int e = 0; e < LP_NBITS * LP_CPB + 10; e++) begin
      rx_in   = (e < LP_NBITS * LP_CPB) ? fb[e / LP_CPB] : 1'b1;
      rden_in = (pop_at > 0) && (e + 1 == pop_at);
      @(negedge clock);
      if (!was_valid && lat < 0 && data_valid_out) lat = e;
      @(posedge clock);
      #1;
    end
    rden_in = 1'b0;
    rx_in   = 1'b1;
    if (good) begin
      if (!exp_valid || pop_at > 0) begin
        exp_data  = b;
        exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
      if (!was_valid) chk("rx_latency_ok", (lat >= 0) && (lat <= LP_LAT_MAX), 1'b1);
    end
    @(negedge clock);
    chk("rx_valid", data_valid_out, exp_valid);
    chk("rx_data", data_out, exp_data);
    chk("rx_overrun", overrun_out, exp_ovr);
  endtask

  task automatic pop();
    rden_in = 1'b1;
    @(posedge clock);
    #1 rden_in = 1'b0;
    exp_valid = 1'b0;
    @(negedge clock);
    chk("pop_valid", data_valid_out, 1'b0);
    chk("pop_data_kept", data_out, exp_data);
    chk("pop_overrun", overrun_out, exp_ovr);
  endtask

  task automatic glitch();
    @(posedge clock);
    #1 rx_in = 1'b0;
    @(posedge clock);
    #1 rx_in = 1'b1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("glitch_valid", data_valid_out, exp_valid);
    chk("glitch_data", data_out, exp_data);
  endtask

  initial begin
    int lat;
    int lat_11;
    int op;
    logic [7:0] rb;

    do_reset();
    chk("rst_tx", tx_out, 1'b1);
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_valid", data_valid_out, 1'b0);
    chk("rst_overrun", overrun_out, 1'b0);
    chk("rst_data", data_out, 8'h00);

    // TX: 0xA5 with an ignored mid-frame write, then back-to-back random frames
    tx_frame(8'hA5, 10, -1);
    tx_frame(8'($urandom), -1, -1);
    tx_frame(8'($urandom), -1, -1);

    // Reset during data bit 4, then a clean frame
    tx_frame(8'hC3, -1, 21);
    tx_frame(8'h81, -1, -1);

    // RX basic receive and pop
    rx_frame(8'h5A, 1'b1, 1'b0, 0, lat);
    pop();

    // Errors: glitch and framing error leave the register empty
    glitch();
    rx_frame(8'h77, 1'b0, 1'b0, 0, lat);
`ifdef SERIAL_UART_PARITY_EN
    rx_frame(8'h03, 1'b1, 1'b1, 0, lat);
`endif

    // Overrun without pop
    do_reset();
    rx_frame(8'h11, 1'b1, 1'b0, 0, lat_11);
    rx_frame(8'h22, 1'b1, 1'b0, 0, lat);

    // Pop on the exact completion edge of the second byte
    do_reset();
    chk("ovr_cleared_by_reset", overrun_out, 1'b0);
    rx_frame(8'h11, 1'b1, 1'b0, 0, lat_11);
    rx_frame(8'h22, 1'b1, 1'b0, lat_11, lat);

    // Randomized mix of operations
    do_reset();
    for (int i = 0; i < 10; i++) begin
      op = int'($urandom_range(0, 3));
      rb = 8'($urandom);
      case (op)
        0: rx_frame(rb, 1'b1, 1'b0, 0, lat);
        1: pop();
        2: tx_frame(rb, -1, -1);
        default: rx_frame(rb, 1'b0, 1'b0, 0, lat);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
